spi_lcd_rx: RTL and testbench

SPI_LCD_RX -- requirements
Module: spi_lcd_rx

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/spi_byte_rx.sv | 82 ++++++++
 rtl/spi_lcd_rx.sv | 208 ++++++++++++++++++++
 tb/tb_spi_lcd_rx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD SPI receiver.
//   - Opcodes of the display commands that the decoder acts on.
//   - Decoder FSM state encoding (also exported on the debug port).
//   - cmd_next_state(): maps a command byte to the decoder state that
//     interprets the data bytes following it.
package lcd_pkg;

  localparam logic [7:0] op_nop   = 8'h00;
  localparam logic [7:0] op_caset = 8'h2A;
  localparam logic [7:0] op_raset = 8'h2B;
  localparam logic [7:0] op_ramwr = 8'h2C;

  typedef enum logic [2:0] {
    st_idle  = 3'd0,
    st_args  = 3'd1,
    st_caset = 3'd2,
    st_raset = 3'd3,
    st_ramwr = 3'd4
  } lcd_state_t;

  function automatic lcd_state_t cmd_next_state(input logic [7:0] op);
    case (op)
      op_caset: cmd_next_state = st_caset;
      op_raset: cmd_next_state = st_raset;
      op_ramwr: cmd_next_state = st_ramwr;
      default:  cmd_next_state = st_args;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI byte receiver (display side, mode 3: clock idles high, sample on rise).
// All five pins are brought into clk_spi through 2-flop synchronizers. A
// rising edge of the synchronized clock while csn is low shifts mosi in,
// MSB first. The 8th sampled bit completes a byte; byte_valid is a
// combinational strobe in the cycle that edge is detected, with byte_data
// and byte_dc (dc captured at that same edge) valid alongside it.
//
// Ports:
//   clk_spi, reset        : system clock, synchronous active-high reset
//   spi_csn/clk/mosi/dc/resn : asynchronous SPI pins
//   core_reset            : reset for everything past the synchronizers
//                           (reset or synchronized spi_resn low)
//   byte_valid/byte_data/byte_dc : completed byte
module spi_byte_rx (
  input  logic       clk_spi,
  input  logic       reset,
  input  logic       spi_csn,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_resn,
  output logic       core_reset,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [1:0] csn_ff, sck_ff, mosi_ff, dc_ff, resn_ff;
  logic       csn_s, sck_s, mosi_s, dc_s;
  logic       sck_prev;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       sample;

  // Synchronizers: only the system reset touches these. resn starts low so
  // the core stays in reset until the real pin level has propagated.
  always_ff @(posedge clk_spi) begin
    if (reset) begin
      csn_ff  <= 2'b11;
      sck_ff  <= 2'b11;
      mosi_ff <= 2'b00;
      dc_ff   <= 2'b00;
      resn_ff <= 2'b00;
    end else begin
      csn_ff  <= {csn_ff[0], spi_csn};
      sck_ff  <= {sck_ff[0], spi_clk};
      mosi_ff <= {mosi_ff[0], spi_mosi};
      dc_ff   <= {dc_ff[0], spi_dc};
      resn_ff <= {resn_ff[0], spi_resn};
    end
  end

  assign csn_s      = csn_ff[1];
  assign sck_s      = sck_ff[1];
  assign mosi_s     = mosi_ff[1];
  assign dc_s       = dc_ff[1];
  assign core_reset = reset | ~resn_ff[1];

  assign sample = sck_s & ~sck_prev & ~csn_s;

  // sck_prev resets high (idle level) so leaving reset never looks like a rise.
  always_ff @(posedge clk_spi) begin
    if (core_reset) begin
      sck_prev <= 1'b1;
      bit_cnt  <= 3'd0;
      shreg    <= 7'd0;
    end else begin
      sck_prev <= sck_s;
      if (csn_s) begin
        bit_cnt <= 3'd0;
      end else if (sample) begin
        shreg   <= {shreg[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign byte_valid = sample & (bit_cnt == 3'd7) & ~core_reset;
  assign byte_data  = {shreg, mosi_s};
  assign byte_dc    = dc_s;

endmodule

// File: rtl/spi_lcd_rx.sv
// LCD SPI command decoder. Receives bytes from spi_byte_rx and interprets
// them like a simple display controller:
//   - dc=0 bytes are commands (cmd_valid/cmd); CASET/RASET/RAMWR select
//     special decoder states, any other command selects ARGS.
//   - dc=1 bytes outside RAMWR are arguments (arg_valid/arg); in CASET and
//     RASET the first four load the column/row window.
//   - dc=1 bytes in RAMWR are pixel data; each full pixel pulses px_we at
//     the cursor, which raster-scans the window. frame_end accompanies the
//     pixel that wraps the window.
// All strobes are registered: they appear one clk_spi cycle after the
// completing SPI edge is detected.
//
// Ports: clk_spi, reset (sync, active-high), SPI pins, the output strobes
// listed above, and dbg_state (current decoder state).
module spi_lcd_rx
  import lcd_pkg::*;
#(
  parameter int c_x_bits     = 8,
  parameter int c_y_bits     = 8,
  parameter int c_color_bits = 16
) (
  input  logic                    clk_spi,
  input  logic                    reset,
  input  logic                    spi_csn,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  input  logic                    spi_dc,
  input  logic                    spi_resn,
  output logic                    cmd_valid,
  output logic [7:0]              cmd,
  output logic                    arg_valid,
  output logic [7:0]              arg,
  output logic                    px_we,
  output logic [c_x_bits-1:0]     px_x,
  output logic [c_y_bits-1:0]     px_y,
  output logic [c_color_bits-1:0] px_color,
  output logic                    frame_end,
  output lcd_state_t              dbg_state
);

  localparam bit color16 = (c_color_bits == 16);

  logic       core_reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;

  spi_byte_rx u_byte_rx (
    .clk_spi    (clk_spi),
    .reset      (reset),
    .spi_csn    (spi_csn),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc),
    .spi_resn   (spi_resn),
    .core_reset (core_reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc)
  );

  lcd_state_t              state_q, state_n;
  logic [2:0]              arg_idx_q, arg_idx_n;   // saturates at 4
  logic [7:0]              hi_q, hi_n;             // pending high address byte
  logic [c_x_bits-1:0]     xs_q, xs_n, xe_q, xe_n, cur_x_q, cur_x_n;
  logic [c_y_bits-1:0]     ys_q, ys_n, ye_q, ye_n, cur_y_q, cur_y_n;
  logic                    phase_q, phase_n;       // 1: high colour byte held
  logic [7:0]              color_hi_q, color_hi_n;
  logic                    cmd_valid_n, arg_valid_n, px_we_n, frame_end_n;
  logic [7:0]              cmd_n, arg_n;
  logic [c_x_bits-1:0]     px_x_n;
  logic [c_y_bits-1:0]     px_y_n;
  logic [c_color_bits-1:0] px_color_n;
  logic [15:0]             addr_pair;
  logic [15:0]             color_word;

  assign addr_pair  = {hi_q, byte_data};
  assign color_word = color16 ? {color_hi_q, byte_data} : {8'h00, byte_data};
  assign dbg_state  = state_q;

  always_ff @(posedge clk_spi) begin
    if (core_reset) begin
      state_q    <= st_idle;
      arg_idx_q  <= 3'd0;
      hi_q       <= 8'd0;
      xs_q       <= '0;
      xe_q       <= '1;
      ys_q       <= '0;
      ye_q       <= '1;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      phase_q    <= 1'b0;
      color_hi_q <= 8'd0;
      cmd_valid  <= 1'b0;
      cmd        <= 8'd0;
      arg_valid  <= 1'b0;
      arg        <= 8'd0;
      px_we      <= 1'b0;
      px_x       <= '0;
      px_y       <= '0;
      px_color   <= '0;
      frame_end  <= 1'b0;
    end else begin
      state_q    <= state_n;
      arg_idx_q  <= arg_idx_n;
      hi_q       <= hi_n;
      xs_q       <= xs_n;
      xe_q       <= xe_n;
      ys_q       <= ys_n;
      ye_q       <= ye_n;
      cur_x_q    <= cur_x_n;
      cur_y_q    <= cur_y_n;
      phase_q    <= phase_n;
      color_hi_q <= color_hi_n;
      cmd_valid  <= cmd_valid_n;
      cmd        <= cmd_n;
      arg_valid  <= arg_valid_n;
      arg        <= arg_n;
      px_we      <= px_we_n;
      px_x       <= px_x_n;
      px_y       <= px_y_n;
      px_color   <= px_color_n;
      frame_end  <= frame_end_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    arg_idx_n   = arg_idx_q;
    hi_n        = hi_q;
    xs_n        = xs_q;
    xe_n        = xe_q;
    ys_n        = ys_q;
    ye_n        = ye_q;
    cur_x_n     = cur_x_q;
    cur_y_n     = cur_y_q;
    phase_n     = phase_q;
    color_hi_n  = color_hi_q;
    cmd_valid_n = 1'b0;
    cmd_n       = cmd;
    arg_valid_n = 1'b0;
    arg_n       = arg;
    px_we_n     = 1'b0;
    px_x_n      = px_x;
    px_y_n      = px_y;
    px_color_n  = px_color;
    frame_end_n = 1'b0;

    if (byte_valid) begin
      if (!byte_dc) begin
        // Any command ends the previous one; a half-received pixel is dropped.
        cmd_valid_n = 1'b1;
        cmd_n       = byte_data;
        state_n     = cmd_next_state(byte_data);
        arg_idx_n   = 3'd0;
        phase_n     = 1'b0;
        if (state_n == st_ramwr) begin
          cur_x_n = xs_q;
          cur_y_n = ys_q;
        end
      end else if (state_q == st_ramwr) begin
        if (color16 && !phase_q) begin
          color_hi_n = byte_data;
          phase_n    = 1'b1;
        end else begin
          px_we_n    = 1'b1;
          px_x_n     = cur_x_q;
          px_y_n     = cur_y_q;
          px_color_n = c_color_bits'(color_word);
          phase_n    = 1'b0;
          // xs>xe (or ys>ye) collapses the window to its start column (row).
          if (cur_x_q == xe_q || xs_q > xe_q) begin
            cur_x_n = xs_q;
            if (cur_y_q == ye_q || ys_q > ye_q) begin
              cur_y_n     = ys_q;
              frame_end_n = 1'b1;
            end else begin
              cur_y_n = cur_y_q + c_y_bits'(1);
            end
          end else begin
            cur_x_n = cur_x_q + c_x_bits'(1);
          end
        end
      end else begin
        arg_valid_n = 1'b1;
        arg_n       = byte_data;
        if (arg_idx_q != 3'd4) begin
          arg_idx_n = arg_idx_q + 3'd1;
        end
        if (state_q == st_caset || state_q == st_raset) begin
          case (arg_idx_q)
            3'd0, 3'd2: hi_n = byte_data;
            3'd1: begin
              if (state_q == st_caset) xs_n = c_x_bits'(addr_pair);
              else                     ys_n = c_y_bits'(addr_pair);
            end
            3'd3: begin
              if (state_q == st_caset) xe_n = c_x_bits'(addr_pair);
              else                     ye_n = c_y_bits'(addr_pair);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Bench for spi_lcd_rx. SPI bytes are driven at clk_spi/4; every byte also
// goes through a behavioural display model that pushes the expected output
// event. A monitor compares each DUT strobe against the queue head.
module tb_spi_lcd_rx;
  import lcd_pkg::*;

  localparam int EW = 44;  // {flags cmd/arg/px [3], data8, x8, y8, color16, frame_end}

  logic       clk_spi = 1'b0;
  logic       reset;
  logic       spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn;
  logic       cmd_valid, arg_valid, px_we, frame_end;
  logic [7:0] cmd, arg, px_x, px_y;
  logic [15:0] px_color;
  lcd_state_t dbg_state;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  bit toggle_cs = 1'b0;

  // behavioural display model
  int m_mode;  // 0 idle, 1 args, 2 caset, 3 raset, 4 ramwr
  int m_arg, m_xs, m_xe, m_ys, m_ye, m_pix;
  logic [7:0] m_hi, m_chi;
  bit m_have_hi;

  spi_lcd_rx dut (
    .clk_spi   (clk_spi),
    .reset     (reset),
    .spi_csn   (spi_csn),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_dc    (spi_dc),
    .spi_resn  (spi_resn),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .arg_valid (arg_valid),
    .arg       (arg),
    .px_we     (px_we),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_color  (px_color),
    .frame_end (frame_end),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk_spi = ~clk_spi;

  function automatic logic [EW-1:0] ev(input logic [2:0] f, input logic [7:0] d,
                                       input logic [7:0] x, input logic [7:0] y,
                                       input logic [15:0] c, input logic fe);
    return {f, d, x, y, c, fe};
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_arg = 0; m_pix = 0; m_have_hi = 0;
    m_xs = 0; m_xe = 255; m_ys = 0; m_ye = 255;
    m_hi = 8'h00; m_chi = 8'h00;
  endfunction

  function automatic void model_byte(input logic dc, input logic [7:0] b);
    int w, h, k;
    if (!dc) begin
      exp_q.push_back(ev(3'b100, b, 8'h0, 8'h0, 16'h0, 1'b0));
      m_arg = 0;
      m_have_hi = 0;
      case (b)
        8'h2A:   m_mode = 2;
        8'h2B:   m_mode = 3;
        8'h2C:   begin m_mode = 4; m_pix = 0; end
        default: m_mode = 1;
      endcase
    end else if (m_mode == 4) begin
      if (!m_have_hi) begin
        m_chi = b;
        m_have_hi = 1;
      end else begin
        w = (m_xs > m_xe) ? 1 : m_xe - m_xs + 1;
        h = (m_ys > m_ye) ? 1 : m_ye - m_ys + 1;
        k = m_pix % (w * h);
        exp_q.push_back(ev(3'b001, 8'h0, 8'(m_xs + k % w), 8'(m_ys + k / w),
                           {m_chi, b}, k == w * h - 1));
        m_pix++;
        m_have_hi = 0;
      end
    end else begin
      exp_q.push_back(ev(3'b010, b, 8'h0, 8'h0, 16'h0, 1'b0));
      if (m_mode == 2 || m_mode == 3) begin
        // a 16-bit address truncated to 8 bits keeps the low byte
        case (m_arg)
          0, 2: m_hi = b;
          1: if (m_mode == 2) m_xs = ({m_hi, b}) % 256; else m_ys = ({m_hi, b}) % 256;
          3: if (m_mode == 2) m_xe = ({m_hi, b}) % 256; else m_ye = ({m_hi, b}) % 256;
          default: ;
        endcase
      end
      m_arg++;
    end
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_spi);
    #1;
  endtask

  task automatic cs_low();
    spi_csn = 1'b0;
    tick(3);
  endtask

  task automatic cs_high();
    tick(4);
    spi_csn = 1'b1;
    tick(4);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_clk  = 1'b0;
      spi_mosi = b[i];
      tick(2);
      spi_clk  = 1'b1;
      tick(2);
    end
  endtask

  task automatic spi_byte(input logic dc, input logic [7:0] b);
    model_byte(dc, b);
    if (toggle_cs) cs_low();
    spi_dc = dc;
    spi_bits(b, 8);
    if (toggle_cs) cs_high();
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] a2, input logic [7:0] a3, input int nargs);
    logic [7:0] a[4];
    a = '{a0, a1, a2, a3};
    spi_byte(1'b0, c);
    for (int i = 0; i < nargs; i++) spi_byte(1'b1, a[i]);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    tick(4);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
    end
  endtask

  task automatic rand_txn();
    int r, n;
    logic [7:0] c;
    r = $urandom_range(0, 4);
    case (r)
      0, 1: begin
        send_cmd(r == 0 ? op_caset : op_raset, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                 8'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 4);
        if ($urandom_range(0, 3) == 0) spi_byte(1'b1, 8'($urandom));
      end
      2: begin
        spi_byte(1'b0, op_ramwr);
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) spi_byte(1'b1, 8'($urandom));
      end
      3: begin
        c = 8'($urandom);
        if (c == op_caset || c == op_raset || c == op_ramwr) c = op_nop;
        spi_byte(1'b0, c);
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) spi_byte(1'b1, 8'($urandom));
      end
      default: spi_byte(1'b1, 8'($urandom));
    endcase
  endtask

  // scoreboard monitor
  always @(negedge clk_spi) begin
    logic [EW-1:0] act, expv;
    if (!reset && (cmd_valid || arg_valid || px_we || frame_end)) begin
      act = ev({cmd_valid, arg_valid, px_we},
               cmd_valid ? cmd : (arg_valid ? arg : 8'h0),
               px_we ? px_x : 8'h0, px_we ? px_y : 8'h0,
               px_we ? px_color : 16'h0, frame_end);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event act=%h exp=none", act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          bad++;
          $display("FAIL event act=%h exp=%h", act, expv);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; spi_csn = 1'b1; spi_clk = 1'b1; spi_mosi = 1'b0;
    spi_dc = 1'b0; spi_resn = 1'b1;
    model_reset();
    tick(5);
    reset = 1'b0;
    tick(4);

    // reset state
    @(negedge clk_spi);
    chk("rst_state", 32'(dbg_state), 32'(st_idle));
    chk("rst_strobes", {cmd_valid, arg_valid, px_we, frame_end}, 4'h0);
    chk("rst_cmd", cmd, 8'h00);
    chk("rst_arg", arg, 8'h00);
    chk("rst_px_xy", {px_x, px_y}, 16'h0);
    chk("rst_px_color", px_color, 16'h0);
    tick(1);

    // CASET 10..19, one-row window, then 12 pixels to show the column wrap
    cs_low();
    send_cmd(op_caset, 8'h00, 8'h0A, 8'h00, 8'h13, 4);
    send_cmd(op_raset, 8'h00, 8'h00, 8'h00, 8'h00, 4);
    spi_byte(1'b0, op_ramwr);
    for (int i = 0; i < 24; i++) spi_byte(1'b1, 8'(i * 7 + 3));
    cs_high();
    drain();
    chk("caset_state", 32'(dbg_state), 32'(st_ramwr));

    // 2x2 window, four RGB565 pixels
    cs_low();
    send_cmd(op_caset, 8'h00, 8'h00, 8'h00, 8'h01, 4);
    send_cmd(op_raset, 8'h00, 8'h00, 8'h00, 8'h01, 4);
    spi_byte(1'b0, op_ramwr);
    begin
      logic [7:0] px_bytes[8];
      px_bytes = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
      for (int i = 0; i < 8; i++) spi_byte(1'b1, px_bytes[i]);
    end
    // spi_resn low mid-byte: partial byte dropped, window back to defaults
    spi_byte(1'b0, 8'h55);
    spi_dc = 1'b1;
    drain();
    spi_bits(8'hA5, 4);
    spi_resn = 1'b0;
    tick(10);
    spi_resn = 1'b1;
    tick(4);
    cs_high();
    exp_q.delete();
    model_reset();
    @(negedge clk_spi);
    chk("resn_state", 32'(dbg_state), 32'(st_idle));
    chk("resn_cmd", cmd, 8'h00);
    chk("resn_px", {px_x, px_y, px_color}, 32'h0);
    tick(1);
    cs_low();
    spi_byte(1'b0, op_ramwr);
    for (int i = 0; i < 6; i++) spi_byte(1'b1, 8'(8'h90 + i));
    send_cmd(op_caset, 8'h01, 8'h03, 8'h00, 8'h05, 4);
    spi_byte(1'b0, op_ramwr);
    for (int i = 0; i < 8; i++) spi_byte(1'b1, 8'(8'h40 + i));
    // partial pixel then NOP
    spi_byte(1'b0, op_ramwr);
    spi_byte(1'b1, 8'hAB);
    spi_byte(1'b0, op_nop);
    cs_high();
    drain();
    chk("nop_state", 32'(dbg_state), 32'(st_args));

    // degenerate window xs>xe, ys>ye
    cs_low();
    send_cmd(op_caset, 8'h00, 8'h05, 8'h00, 8'h02, 4);
    send_cmd(op_raset, 8'h00, 8'h07, 8'h00, 8'h03, 4);
    spi_byte(1'b0, op_ramwr);
    for (int i = 0; i < 6; i++) spi_byte(1'b1, 8'($urandom));
    cs_high();
    drain();

    // random traffic, csn held low across the whole batch
    cs_low();
    for (int t = 0; t < 40; t++) rand_txn();
    cs_high();
    drain();

    // random traffic with csn toggled around every byte
    toggle_cs = 1'b1;
    for (int t = 0; t < 15; t++) rand_txn();
    toggle_cs = 1'b0;
    drain();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
